// File: rtl/msg_process_ctrl_if.sv
// msg_process_ctrl_if
// Bundles every signal between the message requesters, the datapath and the
// msg_process_ctrl controller.
//   req0/msg0, req1/msg1 : requester level requests and their 5-bit messages
//   abort, co2           : transmission abort and datapath frame-complete carry
//   ld, en, dp_clr, msg  : datapath load strobe, shift enable, counter clear, message
//   ack0, ack1           : one-cycle grant pulses back to the requesters
//   busy, done           : transaction in progress / normal completion pulse
// master = environment (requesters + datapath), slave = the controller.
interface msg_process_ctrl_if #(
   parameter int MSG_W = 5
);
   logic             req0;
   logic [MSG_W-1:0] msg0;
   logic             req1;
   logic [MSG_W-1:0] msg1;
   logic             abort;
   logic             co2;
   logic             ld;
   logic             en;
   logic             dp_clr;
   logic [MSG_W-1:0] msg;
   logic             ack0;
   logic             ack1;
   logic             busy;
   logic             done;

   modport master (
      output req0, msg0, req1, msg1, abort, co2,
      input  ld, en, dp_clr, msg, ack0, ack1, busy, done
   );

   modport slave (
      input  req0, msg0, req1, msg1, abort, co2,
      output ld, en, dp_clr, msg, ack0, ack1, busy, done
   );
endinterface

// File: rtl/msg_process_ctrl.sv
// msg_process_ctrl
// Round-robin arbiter and controller for the modulation message datapath.
// Accepts a message from one of two requesters, loads it into the datapath,
// enables serialisation until the frame-complete carry, then reports done.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : msg_process_ctrl_if slave modport (requests, datapath controls, status)
module msg_process_ctrl #(
   parameter int MSG_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   msg_process_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   logic             last;
   logic             winner;
   logic [MSG_W-1:0] msg_reg;
   logic             pick;
   logic [MSG_W-1:0] pick_msg;

   // Arbitration decision for the current IDLE cycle: a lone requester wins,
   // on a tie the requester that did not win last time gets the grant.
   always_comb begin
      pick = bus.req1;
      if (bus.req0 && bus.req1) begin
         pick = ~last;
      end
      pick_msg = pick ? bus.msg1 : bus.msg0;
   end

   // Single FSM process. Every output is a register written together with the
   // next state, so each output reflects the state being entered. Strobes
   // default to 0 each cycle and are only raised for the state being entered.
   // The round-robin pointer moves only when SEND is left (done or abort), so
   // an abort during LOAD leaves the arbitration order unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last       <= 1'b1;
         winner     <= 1'b0;
         msg_reg    <= '0;
         bus.ld     <= 1'b0;
         bus.en     <= 1'b0;
         bus.dp_clr <= 1'b0;
         bus.msg    <= '0;
         bus.ack0   <= 1'b0;
         bus.ack1   <= 1'b0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
      end else begin
         bus.ld     <= 1'b0;
         bus.en     <= 1'b0;
         bus.dp_clr <= 1'b0;
         bus.msg    <= '0;
         bus.ack0   <= 1'b0;
         bus.ack1   <= 1'b0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  state      <= LOAD;
                  winner     <= pick;
                  msg_reg    <= pick_msg;
                  bus.ld     <= 1'b1;
                  bus.dp_clr <= 1'b1;
                  bus.msg    <= pick_msg;
                  bus.ack0   <= ~pick;
                  bus.ack1   <= pick;
                  bus.busy   <= 1'b1;
               end
            end
            LOAD: begin
               if (bus.abort) begin
                  state      <= IDLE;
                  bus.dp_clr <= 1'b1;
               end else begin
                  state    <= SEND;
                  bus.en   <= 1'b1;
                  bus.busy <= 1'b1;
                  bus.msg  <= msg_reg;
               end
            end
            SEND: begin
               // abort takes priority over a coincident co2
               if (bus.abort) begin
                  state      <= IDLE;
                  last       <= winner;
                  bus.dp_clr <= 1'b1;
               end else if (bus.co2) begin
                  state    <= DONE;
                  last     <= winner;
                  bus.done <= 1'b1;
               end else begin
                  bus.en   <= 1'b1;
                  bus.busy <= 1'b1;
                  bus.msg  <= msg_reg;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_process_ctrl.sv
// tb_msg_process_ctrl
// Self-checking bench for msg_process_ctrl: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a transaction-level model.
module tb_msg_process_ctrl;
   localparam int MSG_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // 100 MHz style free-running clock
   always #5 clk = ~clk;

   msg_process_ctrl_if #(.MSG_W(MSG_W)) bus ();

   msg_process_ctrl #(.MSG_W(MSG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Requester behaviour: a request stays up until its ack unless hold is set
   bit         r0, r1, hold0, hold1;
   logic [4:0] m0, m1;

   // Transaction model: mAge counts cycles since the load cycle (0 = load)
   bit         mBusy, mWinner, mLast, mDone, mClr;
   int         mAge;
   logic [4:0] mMsg;
   int         grantLog[$];
   logic [4:0] msgLog[$];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mBusy = 0; mWinner = 0; mLast = 1; mDone = 0; mClr = 0; mAge = 0; mMsg = '0;
   endtask

   // One clock edge of the reference: a request starts a transaction whose
   // load cycle is age 0; it ends on abort (any age) or co2 (age >= 1), a
   // normal end being followed by a single done cycle that ignores requests.
   task automatic modelEdge(input bit q0, input bit q1, input logic [4:0] d0,
                            input logic [4:0] d1, input bit ab, input bit c2);
      bit wasDone;
      wasDone = mDone;
      mDone = 0;
      mClr  = 0;
      if (wasDone) begin
         mBusy = 0;
      end else if (!mBusy) begin
         if (q0 || q1) begin
            mWinner = (q0 && q1) ? !mLast : q1;
            mMsg    = mWinner ? d1 : d0;
            mBusy   = 1;
            mAge    = 0;
            mClr    = 1;
            grantLog.push_back(int'(mWinner));
            msgLog.push_back(mMsg);
         end
      end else if (ab) begin
         if (mAge > 0) mLast = mWinner;
         mBusy = 0;
         mClr  = 1;
      end else if (mAge > 0 && c2) begin
         mLast = mWinner;
         mBusy = 0;
         mDone = 1;
      end else begin
         mAge++;
      end
   endtask

   task automatic compareAll();
      bit expLd;
      expLd = mBusy && (mAge == 0);
      checkOutput("ld",     32'(bus.ld),     32'(expLd));
      checkOutput("en",     32'(bus.en),     32'(mBusy && mAge > 0));
      checkOutput("dp_clr", 32'(bus.dp_clr), 32'(mClr));
      checkOutput("ack0",   32'(bus.ack0),   32'(expLd && !mWinner));
      checkOutput("ack1",   32'(bus.ack1),   32'(expLd && mWinner));
      checkOutput("busy",   32'(bus.busy),   32'(mBusy));
      checkOutput("done",   32'(bus.done),   32'(mDone));
      checkOutput("msg",    32'(bus.msg),    32'(mBusy ? mMsg : 5'd0));
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model at the
   // rising edge and compare shortly after it. Requesters drop after an ack.
   task automatic applyStimulus(input bit ab, input bit c2);
      @(negedge clk);
      bus.req0  = r0;
      bus.msg0  = m0;
      bus.req1  = r1;
      bus.msg1  = m1;
      bus.abort = ab;
      bus.co2   = c2;
      @(posedge clk);
      modelEdge(r0, r1, m0, m1, ab, c2);
      #1;
      compareAll();
      if (mBusy && mAge == 0 && !mWinner && !hold0) r0 = 0;
      if (mBusy && mAge == 0 &&  mWinner && !hold1) r1 = 0;
   endtask

   // Asynchronous reset raised between edges; outputs must clear at once
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.abort = 0; bus.co2 = 0;
      r0 = 0; r1 = 0; hold0 = 0; hold1 = 0;
      #1;
      modelReset();
      checkOutput("rst_en",   32'(bus.en),   32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_msg",  32'(bus.msg),  32'd0);
      compareAll();
      @(posedge clk);
      #1;
      compareAll();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.req0 = 0; bus.msg0 = '0; bus.req1 = 0; bus.msg1 = '0;
      bus.abort = 0; bus.co2 = 0;
      r0 = 0; r1 = 0; hold0 = 0; hold1 = 0; m0 = '0; m1 = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      compareAll();
      @(negedge clk);
      rst = 1'b0;

      // Single request from reset
      r0 = 1; m0 = 5'b10110;
      applyStimulus(0, 0);
      checkOutput("single_ack0", 32'(bus.ack0), 32'd1);
      checkOutput("single_msg",  32'(bus.msg),  32'h16);
      repeat (3) applyStimulus(0, 0);
      applyStimulus(0, 1);
      checkOutput("single_done", 32'(bus.done), 32'd1);
      repeat (2) applyStimulus(0, 0);

      // Contention from reset: both held, co2 five cycles after en rises
      doReset();
      grantLog.delete();
      msgLog.delete();
      r0 = 1; r1 = 1; hold0 = 1; hold1 = 1; m0 = 5'h03; m1 = 5'h1C;
      for (int i = 0; i < 38; i++) applyStimulus(0, mBusy && mAge == 6);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rr_grant%0d", i),
                     (i < grantLog.size()) ? 32'(grantLog[i]) : 32'hF, 32'(i % 2));
         checkOutput($sformatf("rr_msg%0d", i),
                     (i < msgLog.size()) ? 32'(msgLog[i]) : 32'hFF, (i % 2) ? 32'h1C : 32'h03);
      end
      hold0 = 0; hold1 = 0;
      for (int i = 0; i < 30; i++) applyStimulus(0, mBusy && mAge >= 2);

      // Abort on the third SEND cycle of a req1 transaction, req0 pending
      r1 = 1; m1 = 5'h0A;
      applyStimulus(0, 0);
      checkOutput("abort_ack1", 32'(bus.ack1), 32'd1);
      r0 = 1; m0 = 5'h11;
      repeat (3) applyStimulus(0, 0);
      applyStimulus(1, 0);
      checkOutput("abort_en",   32'(bus.en),     32'd0);
      checkOutput("abort_done", 32'(bus.done),   32'd0);
      checkOutput("abort_clr",  32'(bus.dp_clr), 32'd1);
      applyStimulus(0, 0);
      checkOutput("abort_ack0", 32'(bus.ack0), 32'd1);

      // Abort and co2 together in SEND: abort wins
      applyStimulus(0, 0);
      applyStimulus(1, 1);
      checkOutput("abco_done", 32'(bus.done), 32'd0);
      checkOutput("abco_busy", 32'(bus.busy), 32'd0);
      applyStimulus(0, 0);

      // co2 during LOAD is ignored
      r1 = 1; m1 = 5'h07;
      applyStimulus(0, 0);
      applyStimulus(0, 1);
      checkOutput("ldco_en", 32'(bus.en), 32'd1);
      repeat (2) applyStimulus(0, 0);
      checkOutput("ldco_wait", 32'(bus.busy), 32'd1);
      applyStimulus(0, 1);
      repeat (2) applyStimulus(0, 0);

      // Async reset mid-SEND, then serve req1 with the pointer reset
      r1 = 1; m1 = 5'h19;
      repeat (3) applyStimulus(0, 0);
      doReset();
      r1 = 1; m1 = 5'h05;
      applyStimulus(0, 0);
      checkOutput("post_rst_ack1", 32'(bus.ack1), 32'd1);
      for (int i = 0; i < 6; i++) applyStimulus(0, mBusy && mAge >= 2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (!r0 && ($urandom % 4) == 0) begin r0 = 1; m0 = 5'($urandom); end
         if (!r1 && ($urandom % 4) == 0) begin r1 = 1; m1 = 5'($urandom); end
         if (($urandom % 16) == 0) hold0 = !hold0;
         if (($urandom % 16) == 0) hold1 = !hold1;
         if (($urandom % 700) == 0) doReset();
         applyStimulus(($urandom % 40) == 0, ($urandom % 6) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
